// File: rtl/uart_fifo_pkg.sv
// Shared constants for the UART character FIFO: line-status tag layout and
// default geometry.
package uart_fifo_pkg;

  // Line-status error tag stored alongside each RX character.
  localparam int LSR_ERR_W = 3;
  localparam int ERR_PE    = 0;  // parity error
  localparam int ERR_FE    = 1;  // framing error
  localparam int ERR_BI    = 2;  // break indication

  // Default geometry matches the classic 16550 FIFO.
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x W register array: one synchronous write port and one asynchronous
// read port. There is no reset; validity is tracked by the owner's pointers.
module uart_fifo_mem #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Write the addressed entry on an accepted push.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Fall-through read of the head entry.
  always_comb begin
    rdata = mem[raddr];
  end

endmodule

// File: rtl/uart_fifo_gen.sv
// Parametrised UART character FIFO with first-word fall-through, occupancy
// level, synchronous flush, registered error pulses and a threshold trigger.
// Optional macro UART_FIFO_LSR_ERR_EN adds a per-character line-status tag
// (err_in/err_out) and an "any stored entry errored" flag (err_any).
module uart_fifo_gen
  import uart_fifo_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic              push_in,
  input  logic [DATA_W-1:0] din,
  input  logic              pop_in,
  output logic [DATA_W-1:0] dout,
  output logic [AW:0]       level,
  input  logic [AW:0]       threshold,
  output logic              empty,
  output logic              full,
  output logic              overrun,
  output logic              underrun,
  output logic              thre_trigger
`ifdef UART_FIFO_LSR_ERR_EN
  ,
  input  logic [LSR_ERR_W-1:0] err_in,
  output logic [LSR_ERR_W-1:0] err_out,
  output logic                 err_any
`endif
);

`ifdef UART_FIFO_LSR_ERR_EN
  localparam int SW = DATA_W + LSR_ERR_W;
`else
  localparam int SW = DATA_W;
`endif

  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          hold;
  logic          pop_ok, push_ok;
  logic [SW-1:0] wdata, rdata;

  // While disabled or flushing, the FIFO is forced empty and requests ignored.
  assign hold    = ~en | clr;
  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_FULL);
  assign level   = cnt;
  assign pop_ok  = ~hold & pop_in & ~empty;
  // A push at full is still taken when the head is popped in the same cycle.
  assign push_ok = ~hold & push_in & (~full | pop_ok);

`ifdef UART_FIFO_LSR_ERR_EN
  assign wdata = {err_in, din};
`else
  assign wdata = din;
`endif

  uart_fifo_mem #(
    .W     (SW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // Head data is masked to zero when empty so stale storage never leaks out.
  assign dout = empty ? '0 : rdata[DATA_W-1:0];

  // Pointer and occupancy update; flush/disable wins over push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (hold) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  // Registered error pulses and threshold trigger (lags level by one cycle).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun      <= 1'b0;
      underrun     <= 1'b0;
      thre_trigger <= 1'b0;
    end else begin
      overrun      <= ~hold & push_in & ~push_ok;
      underrun     <= ~hold & pop_in & empty;
      thre_trigger <= (threshold != '0) && (cnt >= threshold);
    end
  end

`ifdef UART_FIFO_LSR_ERR_EN
  logic [AW:0]          err_cnt;
  logic [LSR_ERR_W-1:0] head_err;
  logic                 err_inc, err_dec;

  assign head_err = rdata[SW-1:DATA_W];
  assign err_out  = empty ? '0 : head_err;
  assign err_any  = (err_cnt != '0);
  assign err_inc  = push_ok & (err_in != '0);
  assign err_dec  = pop_ok & (head_err != '0);

  // Count of stored entries carrying a non-zero line-status tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (hold) begin
      err_cnt <= '0;
    end else begin
      case ({err_inc, err_dec})
        2'b10:   err_cnt <= err_cnt + CNT_ONE;
        2'b01:   err_cnt <= err_cnt - CNT_ONE;
        default: err_cnt <= err_cnt;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_uart_fifo_gen.sv
// Self-checking bench for uart_fifo_gen: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
// Build with UART_FIFO_LSR_ERR_EN defined to exercise the error-tag path.
module tb_uart_fifo_gen;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int AW     = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b1;
  logic              clr = 1'b0;
  logic              push_in = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic              pop_in = 1'b0;
  logic [DATA_W-1:0] dout;
  logic [AW:0]       level;
  logic [AW:0]       threshold = '0;
  logic              empty, full, overrun, underrun, thre_trigger;
`ifdef UART_FIFO_LSR_ERR_EN
  logic [2:0]        err_in = '0;
  logic [2:0]        err_out;
  logic              err_any;
`endif

  int errors = 0;
  int checks = 0;

  uart_fifo_gen #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .clr          (clr),
    .push_in      (push_in),
    .din          (din),
    .pop_in       (pop_in),
    .dout         (dout),
    .level        (level),
    .threshold    (threshold),
    .empty        (empty),
    .full         (full),
    .overrun      (overrun),
    .underrun     (underrun),
    .thre_trigger (thre_trigger)
`ifdef UART_FIFO_LSR_ERR_EN
    ,
    .err_in       (err_in),
    .err_out      (err_out),
    .err_any      (err_any)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a queue; rules applied to the pre-edge inputs.
  logic [DATA_W-1:0] mq[$];
  logic [2:0]        meq[$];
  logic              m_over = 1'b0, m_under = 1'b0, m_thre = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    bit did_pop, did_push;
    if (!rst_n) begin
      mq.delete(); meq.delete();
      m_over = 0; m_under = 0; m_thre = 0;
    end else begin
      m_thre = (threshold != 0) && (mq.size() >= int'(threshold));
      if (!en || clr) begin
        mq.delete(); meq.delete();
        m_over = 0; m_under = 0;
      end else begin
        did_pop  = pop_in && (mq.size() > 0);
        did_push = push_in && ((mq.size() < DEPTH) || did_pop);
        m_under  = pop_in && (mq.size() == 0);
        m_over   = push_in && !did_push;
        if (did_pop) begin
          void'(mq.pop_front());
          void'(meq.pop_front());
        end
        if (did_push) begin
          mq.push_back(din);
`ifdef UART_FIFO_LSR_ERR_EN
          meq.push_back(err_in);
`else
          meq.push_back(3'b000);
`endif
        end
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    int n;
    n = mq.size();
    chk("m_level", 32'(level), 32'(n));
    chk("m_empty", 32'(empty), 32'(n == 0));
    chk("m_full", 32'(full), 32'(n == DEPTH));
    chk("m_dout", 32'(dout), (n > 0) ? 32'(mq[0]) : 32'h0);
    chk("m_overrun", 32'(overrun), 32'(m_over));
    chk("m_underrun", 32'(underrun), 32'(m_under));
    chk("m_thre", 32'(thre_trigger), 32'(m_thre));
`ifdef UART_FIFO_LSR_ERR_EN
    begin
      bit any;
      any = 0;
      foreach (meq[i]) if (meq[i] != 0) any = 1;
      chk("m_err_out", 32'(err_out), (n > 0) ? 32'(meq[0]) : 32'h0);
      chk("m_err_any", 32'(err_any), 32'(any));
    end
`endif
  end

  // One clock of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic p, input logic [DATA_W-1:0] d, input logic q);
    push_in = p; din = d; pop_in = q;
    @(posedge clk); #1;
    push_in = 0; pop_in = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_level", 32'(level), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_thre", 32'(thre_trigger), 0);
    rst_n = 1;

    // Fill, then overrun
    for (int i = 1; i <= 16; i++) cyc(1, 8'(i), 0);
    chk("fill_level", 32'(level), 16);
    chk("fill_full", 32'(full), 1);
    chk("fill_dout", 32'(dout), 32'h01);
    cyc(1, 8'hEE, 0);
    chk("ovr_pulse", 32'(overrun), 1);
    chk("ovr_level", 32'(level), 16);
    cyc(0, 0, 0);
    chk("ovr_single", 32'(overrun), 0);

    // Drain in order, then underrun
    for (int i = 1; i <= 16; i++) begin
      chk("drain_dout", 32'(dout), 32'(i));
      cyc(0, 0, 1);
    end
    chk("drain_empty", 32'(empty), 1);
    chk("drain_dout0", 32'(dout), 0);
    cyc(0, 0, 1);
    chk("udr_pulse", 32'(underrun), 1);
    chk("udr_level", 32'(level), 0);
    cyc(0, 0, 0);
    chk("udr_single", 32'(underrun), 0);

    // Wrap-around
    for (int i = 0; i < 10; i++) cyc(1, 8'(8'h30 + i), 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1);
    for (int i = 0; i < 16; i++) cyc(1, 8'(8'hA0 + i), 0);
    chk("wrap_full", 32'(full), 1);
    chk("wrap_head", 32'(dout), 32'hA0);

    // Push and pop together at full
    cyc(1, 8'h55, 1);
    chk("fullpp_ovr", 32'(overrun), 0);
    chk("fullpp_level", 32'(level), 16);
    for (int i = 1; i < 16; i++) begin
      chk("wrap_dout", 32'(dout), 32'(8'hA0 + i));
      cyc(0, 0, 1);
    end
    chk("fullpp_last", 32'(dout), 32'h55);
    cyc(0, 0, 1);
    chk("fullpp_empty", 32'(empty), 1);

    // Push and pop together at empty
    cyc(1, 8'h66, 1);
    chk("emptypp_udr", 32'(underrun), 1);
    chk("emptypp_level", 32'(level), 1);
    chk("emptypp_dout", 32'(dout), 32'h66);
    cyc(0, 0, 1);
    chk("emptypp_drain", 32'(level), 0);

    // Threshold trigger and flush
    threshold = 4;
    for (int i = 0; i < 4; i++) cyc(1, 8'(8'h40 + i), 0);
    chk("thr_level4", 32'(level), 4);
    chk("thr_lag", 32'(thre_trigger), 0);
    cyc(0, 0, 0);
    chk("thr_set", 32'(thre_trigger), 1);
    clr = 1;
    cyc(1, 8'h77, 0);
    clr = 0;
    chk("clr_level", 32'(level), 0);
    chk("clr_empty", 32'(empty), 1);
    chk("clr_ovr", 32'(overrun), 0);
    cyc(0, 0, 0);
    chk("clr_thre", 32'(thre_trigger), 0);
    threshold = 0;

    // Disable holds the FIFO empty and suppresses error pulses
    cyc(1, 8'h11, 0);
    cyc(1, 8'h12, 0);
    en = 0;
    cyc(1, 8'h13, 1);
    chk("dis_level", 32'(level), 0);
    cyc(0, 0, 1);
    chk("dis_udr", 32'(underrun), 0);
    en = 1;
    cyc(0, 0, 0);

`ifdef UART_FIFO_LSR_ERR_EN
    err_in = 3'b000; cyc(1, 8'h10, 0);
    err_in = 3'b010; cyc(1, 8'h20, 0);
    err_in = 3'b000; cyc(1, 8'h30, 0);
    chk("err_any_set", 32'(err_any), 1);
    chk("err_head0", 32'(err_out), 0);
    cyc(0, 0, 1);
    chk("err_head_fe", 32'(err_out), 32'b010);
    chk("err_dout", 32'(dout), 32'h20);
    cyc(0, 0, 1);
    chk("err_any_clr", 32'(err_any), 0);
    chk("err_dout2", 32'(dout), 32'h30);
    err_in = 3'b100; cyc(1, 8'h31, 0);
    err_in = 3'b000;
    chk("err_any_bi", 32'(err_any), 1);
`else
    cyc(1, 8'h31, 0);
    cyc(1, 8'h32, 0);
`endif

    // Asynchronous reset from a non-empty state
    threshold = 1;
    cyc(0, 0, 0);
    cyc(1, 8'h99, 0);
    chk("pre_rst_nonempty", 32'(empty), 0);
    #2;
    rst_n = 0;
    #1;
    chk("arst_level", 32'(level), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_dout", 32'(dout), 0);
    chk("arst_thre", 32'(thre_trigger), 0);
`ifdef UART_FIFO_LSR_ERR_EN
    chk("arst_err_any", 32'(err_any), 0);
    chk("arst_err_out", 32'(err_out), 0);
`endif
    @(posedge clk); #1;
    rst_n = 1;
    threshold = 0;
    cyc(0, 0, 0);
    cyc(0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_fifo_gen.md
# uart_fifo_gen

Parametrised UART character FIFO, the successor of the fixed 8x16 FIFO that sits between the 16550 register file and the TX/RX shift engines. It is a circular buffer with explicit read and write pointers and an occupancy counter, and keeps first-word fall-through output. It adds a level output, a synchronous flush, defined simultaneous push/pop at the full and empty boundaries, and an optional per-character line-status error tag for the RX path.

## Interface
- DATA_W, 8, character width in bits.
- DEPTH, 16, number of entries; power of two, at least 4.
- AW, $clog2(DEPTH), pointer width (derived, not overridden).
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  FIFO enable (FCR[0]); while 0, the FIFO is held empty.
- clr  in  1  synchronous flush (FCR[1]/FCR[2] pulse).
- push_in  in  1  write request.
- din  in  DATA_W  write data.
- pop_in  in  1  read request; consumes the head entry.
- dout  out  DATA_W  head entry (fall-through); 0 when empty.
- level  out  AW+1  current occupancy, 0..DEPTH.
- threshold  in  AW+1  trigger level; 0 disables the trigger.
- empty, full  out  1  occupancy flags.
- overrun, underrun  out  1  single-cycle error pulses.
- thre_trigger  out  1  registered (level >= threshold) with threshold != 0.
- err_in  in  3  {break, framing, parity} tag for din (macro only).
- err_out  out  3  tag of the head entry; 0 when empty (macro only).
- err_any  out  1  at least one stored entry has a non-zero tag, i.e. LSR[7] (macro only).

## Operation
- State: wr_ptr and rd_ptr (AW bits each, wrap modulo DEPTH), cnt (AW+1 bits), plus the storage array.
- Outputs derived from cnt: level = cnt, empty = (cnt==0), full = (cnt==DEPTH).
- Pop acceptance: pop_ok = en & ~clr & pop_in & ~empty.
- Push acceptance: push_ok = en & ~clr & push_in & (~full | pop_ok).
  - A push while full is accepted if a pop is accepted in the same cycle.
- Both accepted: write at wr_ptr, advance both pointers, cnt unchanged.
- Push only: cnt+1. Pop only: cnt-1.
- Push and pop together while empty: the pop is rejected and the push is accepted (cnt becomes 1). The following cycle dout shows the new data.
- overrun pulses for 1 cycle when push_in=1 and push_ok=0 with en=1 and clr=0.
- underrun pulses for 1 cycle when pop_in=1 and empty=1 with en=1 and clr=0.
- clr=1: pointers and cnt go to 0 next cycle. clr has priority over push and pop; no error pulses in that cycle. Storage contents are not cleared.
- en=0: same effect as clr, held continuously; all requests are ignored silently.
- dout = mem[rd_ptr] when not empty, otherwise 0.

## Timing
- Reset (rst_n=0, asynchronous) values: ptrs=0, cnt=0, level=0, empty=1, full=0, overrun=0, underrun=0, thre_trigger=0, dout=0, err_out=0, err_any=0.
- The first edge after rst_n deasserts is a normal operating edge.
- Write-to-read latency is 1 cycle: data pushed at edge N appears on dout after edge N, when empty.
- After a pop at edge N, dout shows the next entry after edge N.
- level, empty and full reflect accepted operations immediately after the edge. They are combinational from cnt only.
- overrun/underrun are registered: they assert in the cycle after the offending request, for exactly 1 cycle per offending cycle.
- thre_trigger is registered from the post-update level, so it is valid the cycle after level changes. It is recomputed every cycle, so a threshold change takes effect within 1 cycle.

## Configuration
- UART_FIFO_LSR_ERR_EN defined:
  - Storage width becomes DATA_W+3 and err_in is stored with each character.
  - err_out gives the head entry's tag.
  - err_any is driven by an errored-entry counter (AW+1 bits). It increments on an accepted push with a non-zero tag and decrements on an accepted pop of a non-zero-tagged head. A simultaneous push and pop apply both.
  - clr, en=0 and reset zero the counter.
- UART_FIFO_LSR_ERR_EN undefined: err_in, err_out and err_any ports are absent. Storage is DATA_W wide. Behaviour is otherwise identical.

## Structure
- Package uart_fifo_pkg holds:
  - LSR_ERR_W = 3;
  - bit indices ERR_PE = 0, ERR_FE = 1, ERR_BI = 2;
  - default DATA_W and DEPTH constants.
- One sub-module, uart_fifo_mem: a DEPTH x W register array with one synchronous write port and one asynchronous read port. It has no reset.
- Pointer, count, flag and error logic live in uart_fifo_gen.

## Test plan
- Reset then fill: DEPTH=16, push 0x01..0x10 -> level=16, full=1, dout=0x01. A 17th push -> overrun=1 for 1 cycle, and contents are unchanged.
- Drain and underrun: pop 16 times -> dout follows 0x01..0x10 in order, then empty=1 and dout=0. One extra pop -> underrun pulse, and level stays 0.
- Wrap-around: push 10, pop 10, push 16 values 0xA0..0xAF -> pointers wrap and the read order is exactly 0xA0..0xAF.
- Boundary simultaneity:
  - At full, push 0x55 and pop together -> no overrun, level stays 16, and 0x55 is read last.
  - At empty, push 0x66 and pop together -> no data lost, underrun pulse, level=1, dout=0x66 next cycle.
- Threshold and flush: threshold=4, push 4 -> thre_trigger=1 one cycle after level=4. clr together with a push -> level=0, empty=1, no overrun, and thre_trigger=0 the following cycle.
- With UART_FIFO_LSR_ERR_EN:
  - Push 0x10 (err 0), 0x20 (err 3'b010), 0x30 (err 0) -> err_any=1.
  - First pop -> err_out=3'b010 at the head.
  - Second pop -> err_any=0.
  - Reset during a non-empty state -> all outputs return to reset values asynchronously.
